uart_board_loader: RTL
======================

Name: uart_board_loader

Overview:
- Inbound path for the Game of Life board: receives a serial UART frame from a host PC and assembles a complete 256-cell board.
- Commits the board atomically, only after the frame checksum passes.
- Sits beside Main_machine; its board_o/load_done feed the machine's seed-load path. It is the input-side counterpart of the board's VGA/SSD output path.
- Contains a byte-level UART receiver plus a frame-level state machine.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200 baud); must be >= 8.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1000000, maximum idle clk cycles between bytes inside a frame before abort.

Ports:
- clk  in  1  system clock, 100 MHz (ClkPort at top level).
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  UART serial input, idle high, asynchronous to clk.
- board_o  out  256  committed board; bit i = cell i (1 = alive).
- load_done  out  1  one-cycle pulse when board_o is updated.
- chk_err  out  1  one-cycle pulse on checksum mismatch.
- frame_err  out  1  one-cycle pulse on stop-bit error or inter-byte timeout inside a frame.
- busy  out  1  high while a frame is in progress (after SYNC accepted, until commit or abort).

Behaviour:

Reset (asynchronous, active-high):
- All outputs 0: board_o = 256'h0, load_done = 0, chk_err = 0, frame_err = 0, busy = 0.
- Both FSMs go to their idle states; the shadow register and XOR accumulator clear.
- Reset asserted mid-frame discards all partial data.

Input synchronizer:
- rx passes through a 2-flop synchronizer, reset value 1.
- All logic uses the synchronized signal.

Byte receiver FSM: R_IDLE -> R_START -> R_DATA -> R_STOP.
- R_IDLE: on a synchronized 1->0 transition, load the bit counter and go to R_START.
- R_START: wait CLKS_PER_BIT/2 cycles, then sample.
  - If rx = 1: false start, return to R_IDLE with no byte.
  - If rx = 0: go to R_DATA.
- R_DATA: sample at every CLKS_PER_BIT interval, 8 bits, LSB first.
- R_STOP: wait CLKS_PER_BIT, then sample the stop bit.
  - If 1: issue a byte_valid strobe (internal, one cycle) with the byte.
  - If 0: issue a byte_err strobe.
  - Either way, return to R_IDLE.

Frame FSM: F_SYNC -> F_DATA -> F_CHECK.
- F_SYNC:
  - byte_valid with byte == SYNC_BYTE: clear the byte index and XOR accumulator, set busy, go to F_DATA.
  - Any other byte: ignored, with no error pulse.
  - byte_err in this state: ignored.
- F_DATA, on each byte_valid:
  - Write shadow[8k+7:8k] = byte, where k = byte index 0..31.
  - XOR the byte into the accumulator and increment k.
  - After k = 31, go to F_CHECK.
  - A SYNC_BYTE value received here is treated as data; no resync.
- F_CHECK, on the next byte_valid:
  - If byte == accumulator: board_o <= shadow and pulse load_done the cycle after the stop-bit sample.
  - Otherwise: pulse chk_err and leave board_o unchanged.
  - Either way, clear busy and go to F_SYNC.
- Abort, in F_DATA or F_CHECK:
  - Triggered by byte_err, or by TIMEOUT_CYCLES consecutive cycles with no byte_valid. The timeout counter restarts on each byte_valid.
  - Response: pulse frame_err, clear busy, return to F_SYNC. board_o is unchanged.
- Output invariants:
  - board_o changes only on a load_done cycle.
  - load_done, chk_err and frame_err are mutually exclusive and never asserted in consecutive cycles from the same frame.

Byte timing:
- Back-to-back bytes (no idle between stop and next start) must be received with no loss.
- Latency from the stop-bit centre sample to the load_done pulse: 1 clk.

Test Plan:
- Use CLKS_PER_BIT = 16 and TIMEOUT_CYCLES = 2000 for all scenarios.
1. Reset: assert reset with rx toggling -> all outputs 0; release -> busy stays 0 until 0xA5 is received.
2. Valid frame: 0xA5, then 32 bytes 0x00..0x1F, then checksum 0x00 (XOR of 0..31) -> busy high from SYNC until commit; load_done is a single pulse; board_o[7:0] = 8'h00, board_o[15:8] = 8'h01, board_o[255:248] = 8'h1F.
3. Bad checksum: 0xA5, 32 x 0xFF, checksum 0x01 (expected 0x00) -> chk_err pulses once; board_o holds the prior value from scenario 2; load_done stays 0.
4. Junk before SYNC: 0x3C, 0x00, then 0xA5, 32 x 0x55, checksum 0x00 -> leading bytes are ignored, no error pulses; board_o = {32{8'h55}}.
5. Stop-bit error: 0xA5 and 10 data bytes, then a byte with stop bit 0 -> frame_err pulse, busy low, board unchanged. Next, a full valid frame -> loads normally.
6. Timeout and reset mid-frame:
   - 0xA5 and 5 bytes, then rx idle for 2000 cycles -> frame_err pulse.
   - Repeat, but assert reset after byte 3 -> board_o = 0 and no pulses.
   - A subsequent valid frame -> loads normally.

Source files
------------

// File: rtl/uart_board_loader.sv
// UART board loader: 8N1 byte receiver plus a framing FSM that assembles a 256-cell
// board behind a SYNC byte and commits it only when the trailing XOR checksum matches.
module uart_board_loader #(
  parameter int         CLKS_PER_BIT   = 868,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx,
  output logic [255:0] board_o,
  output logic         load_done,
  output logic         chk_err,
  output logic         frame_err,
  output logic         busy
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMO_M1  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} r_state_e;
  typedef enum logic [1:0] {F_SYNC, F_DATA, F_CHECK} f_state_e;

  logic sync1_q, sync2_q, rx_prev_q;
  logic rx_s;

  r_state_e        r_state_q, r_state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            byte_valid, byte_err;
  logic [7:0]      rx_byte;

  f_state_e        f_state_q, f_state_d;
  logic [4:0]      idx_q, idx_d;
  logic [7:0]      acc_q, acc_d;
  logic [255:0]    shadow_q, shadow_d;
  logic [255:0]    board_q, board_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            busy_q, busy_d;
  logic            load_done_q, load_done_d;
  logic            chk_err_q, chk_err_d;
  logic            frame_err_q, frame_err_d;

  assign rx_s = sync2_q;

  // Byte receiver; byte_valid/byte_err are combinational strobes on the stop-bit sample
  // so the frame FSM can register its result one clock later.
  always_comb begin
    r_state_d  = r_state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    rx_byte    = shreg_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          r_state_d = R_START;
          cnt_d     = '0;
          bit_d     = '0;
        end
      end
      R_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          r_state_d = rx_s ? R_IDLE : R_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) r_state_d = R_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d      = '0;
          r_state_d  = R_IDLE;
          byte_valid = rx_s;
          byte_err   = !rx_s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    f_state_d   = f_state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    shadow_d    = shadow_q;
    board_d     = board_q;
    tmo_d       = tmo_q;
    busy_d      = busy_q;
    load_done_d = 1'b0;
    chk_err_d   = 1'b0;
    frame_err_d = 1'b0;
    case (f_state_q)
      F_SYNC: begin
        if (byte_valid && rx_byte == SYNC_BYTE) begin
          idx_d     = '0;
          acc_d     = '0;
          tmo_d     = '0;
          busy_d    = 1'b1;
          f_state_d = F_DATA;
        end
      end
      default: begin
        // The idle timer keeps running during a byte; a full byte is far shorter than the limit.
        if (byte_err || (!byte_valid && tmo_q == TMO_M1)) begin
          frame_err_d = 1'b1;
          busy_d      = 1'b0;
          f_state_d   = F_SYNC;
        end else if (byte_valid) begin
          tmo_d = '0;
          if (f_state_q == F_DATA) begin
            shadow_d[{idx_q, 3'b000} +: 8] = rx_byte;
            acc_d = acc_q ^ rx_byte;
            idx_d = idx_q + 1'b1;
            if (idx_q == 5'd31) f_state_d = F_CHECK;
          end else begin
            if (rx_byte == acc_q) begin
              board_d     = shadow_q;
              load_done_d = 1'b1;
            end else begin
              chk_err_d = 1'b1;
            end
            busy_d    = 1'b0;
            f_state_d = F_SYNC;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      r_state_q   <= R_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      f_state_q   <= F_SYNC;
      idx_q       <= '0;
      acc_q       <= '0;
      shadow_q    <= '0;
      board_q     <= '0;
      tmo_q       <= '0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      chk_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= rx;
      sync2_q     <= sync1_q;
      rx_prev_q   <= rx_s;
      r_state_q   <= r_state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      f_state_q   <= f_state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      shadow_q    <= shadow_d;
      board_q     <= board_d;
      tmo_q       <= tmo_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
      chk_err_q   <= chk_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign board_o   = board_q;
  assign load_done = load_done_q;
  assign chk_err   = chk_err_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule
